alu_mul_seq: RTL and testbench

- Multi-cycle unsigned multiply sequencer that reuses the shared integer ALU in ADD mode.
- Computes the low WIDTH bits of op_a*op_b by shift-and-add, so no dedicated multiplier is needed.
- Doubling is done as mcand+mcand through the ALU; the multiplier right-shift is kept internally.
- Sits beside the core datapath. Borrows the ALU through a req/gnt pair that the core's ALU-input mux arbitrates.

---
 rtl/alu_mul_seq.sv | 153 +++++++++++++++
 tb/tb_alu_mul_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//   Multi-cycle unsigned shift-and-add multiplier that borrows the shared
//   integer ALU (ADD mode) instead of using a dedicated multiplier.
//   The product is built as a sum of doubled multiplicands:
//     ACC : if the current multiplier LSB is set, acc <= acc + mcand (ALU)
//     DBL : mcand <= mcand + mcand (ALU), multiplier shifts right
//   Only the low WIDTH bits of op_a*op_b are produced (wraps mod 2^WIDTH).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           pulse; captures op_a/op_b when idle
//   op_a, op_b      multiplicand, multiplier
//   busy            high while in ACC/DBL
//   done            one-cycle completion strobe
//   result          low WIDTH bits of product, held until next start
//   alu_req         ALU wanted this cycle (never depends on alu_gnt)
//   alu_gnt         core grants the ALU this cycle
//   alu_ctrl        ALU_ADD while requesting, else 0
//   alu_op1/op2     ALU operands, 0 while not requesting
//   alu_out         ALU sum, used only when alu_req && alu_gnt
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] ALU_ADD = 3'b000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DBL,
        S_DONE
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] acc_reg,    acc_next;
    logic [WIDTH-1:0] mcand_reg,  mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
        end
    end

    // The ACC step is the last one when no higher multiplier bits remain,
    // or when every bit position has been visited.
    assign last_step = (mplier_reg[WIDTH-1:1] == '0) ||
                       (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        alu_req     = 1'b0;
        alu_ctrl    = 3'b000;
        alu_op1     = '0;
        alu_op2     = '0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    acc_next = '0;
                    if (op_b != '0) begin
                        mcand_next  = op_a;
                        mplier_next = op_b;
                        cnt_next    = '0;
                        state_next  = S_ACC;
                    end else begin
                        state_next  = S_DONE;
                    end
                end
            end

            S_ACC: begin
                if (mplier_reg[0]) begin
                    alu_req  = 1'b1;
                    alu_ctrl = ALU_ADD;
                    alu_op1  = acc_reg;
                    alu_op2  = mcand_reg;
                    if (alu_gnt) begin
                        acc_next   = alu_out;
                        state_next = last_step ? S_DONE : S_DBL;
                    end
                end else begin
                    state_next = last_step ? S_DONE : S_DBL;
                end
            end

            S_DBL: begin
                alu_req  = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_op1  = mcand_reg;
                alu_op2  = mcand_reg;
                if (alu_gnt) begin
                    mcand_next  = alu_out;
                    mplier_next = mplier_reg >> 1;
                    cnt_next    = cnt_reg + CW'(1);
                    state_next  = S_ACC;
                end
            end

            S_DONE: begin
                result_next = acc_reg;
                state_next  = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign busy   = (state_reg == S_ACC) || (state_reg == S_DBL);
    assign done   = (state_reg == S_DONE);
    // The final accumulator is shown directly during the done cycle so the
    // result is valid together with the strobe; afterwards the copy holds it.
    assign result = (state_reg == S_DONE) ? acc_reg : result_reg;

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
//   Self-checking bench for alu_mul_seq. A behavioural ALU adds op1+op2 when
//   granted and returns junk otherwise. Each multiply is checked against
//   a*b mod 2^32, expected busy length 2k+1 (+ stall cycles) and granted
//   request count popcount(b)+k.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;

    localparam int         W       = 32;
    localparam logic [2:0] ALU_ADD = 3'b000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         busy, done;
    logic [W-1:0] result;
    logic         alu_req, alu_gnt;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_op1, alu_op2, alu_out;
    logic [W-1:0] junk;

    int n_checks = 0;
    int n_pass   = 0;

    alu_mul_seq #(.WIDTH(W), .ALU_ADD(ALU_ADD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .alu_req  (alu_req),
        .alu_gnt  (alu_gnt),
        .alu_ctrl (alu_ctrl),
        .alu_op1  (alu_op1),
        .alu_op2  (alu_op2),
        .alu_out  (alu_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) junk <= $urandom;
    assign alu_out = (alu_req && alu_gnt) ? (alu_op1 + alu_op2) : junk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // mode 0: gnt always 1; mode 1: random gnt; mode 2: stall 3 cycles on
    // the first request after the first grant (a DBL when b[0]=1).
    // inject: pulse start with op_b=9 mid-computation (must be ignored).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mode, input bit inject);
        int          cyc = 0, busy_cnt = 0, grants = 0, stalls = 0;
        int          k = 0, stall_left = 3;
        bit          got_done = 0, first_granted = 0;
        logic [W-1:0] exp_res;
        int          exp_busy, exp_grants;

        exp_res = a * b;
        for (int i = 0; i < W; i++) if (b[i]) k = i;

        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; alu_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < 500) begin
            if (inject && cyc == 2) begin
                start = 1'b1; op_a = 32'd77; op_b = 32'd9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got_done = 1;
                check("result_at_done", result, exp_res);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end else begin
                busy_cnt += int'(busy);
                case (mode)
                    0: alu_gnt = 1'b1;
                    1: alu_gnt = ($urandom_range(0, 3) != 0);
                    default: begin
                        alu_gnt = 1'b1;
                        if (alu_req && first_granted && stall_left > 0) begin
                            alu_gnt = 1'b0;
                            stall_left--;
                        end
                    end
                endcase
                if (alu_req) begin
                    check("ctrl_add", {29'd0, alu_ctrl}, {29'd0, ALU_ADD});
                    if (mode == 2 && !alu_gnt) begin
                        check("stall_op1", alu_op1, a);
                        check("stall_op2", alu_op2, a);
                    end
                    if (alu_gnt) begin
                        grants++;
                        first_granted = 1;
                    end else begin
                        stalls++;
                    end
                end else begin
                    check("idle_ctrl_op", {29'd0, alu_ctrl} | alu_op1 | alu_op2, 32'd0);
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        alu_gnt = 1'b1;
        if (!got_done) check("timeout_done", 32'd0, 32'd1);
        exp_busy   = (b == 0) ? 0 : 2 * k + 1 + stalls;
        exp_grants = (b == 0) ? 0 : $countones(b) + k;
        check("busy_cycles", busy_cnt, exp_busy);
        check("done_latency", cyc - 1, exp_busy);
        check("grants", grants, exp_grants);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("result_held", result, exp_res);
        $display("op a=0x%08h b=0x%08h mode=%0d res=0x%08h busy=%0d grants=%0d stalls=%0d",
                 a, b, mode, result, busy_cnt, grants, stalls);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; alu_gnt = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_req", {31'd0, alu_req}, 32'd0);
        check("rst_ops", {29'd0, alu_ctrl} | alu_op1 | alu_op2, 32'd0);
        rst_n = 1'b1;

        run_op(32'd7, 32'd6, 0, 0);
        run_op(32'h1234, 32'd0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(32'd5, 32'd3, 2, 0);
        run_op(32'd3, 32'd4, 0, 1);

        // Reset in the middle of 3*4
        @(negedge clk);
        start = 1'b1; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_req", {31'd0, alu_req}, 32'd0);
        check("midrst_ops", {29'd0, alu_ctrl} | alu_op1 | alu_op2, 32'd0);
        $display("reset mid-operation applied");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd2, 32'd2, 0, 0);

        for (int t = 0; t < 20; t++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, (t % 2 == 0) ? 1 : 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
